// File: rtl/edge_process_if.sv
// Edge-process stage ports: front (fetch side) and out (accumulate side).
interface edge_process_if #(
  parameter int EDGE_PIPE_NUM      = 4,
  parameter int VERTEX_BRAM_DWIDTH = 32,
  parameter int WEIGHT_DWIDTH      = 8,
  parameter int DST_CH_NUM         = 4,
  parameter int DST_ID_DWIDTH      = 20,
  parameter int MASK_WIDTH         = 4,
  parameter int TOT_ACC_ID_WIDTH   = 4
);
  localparam int EPN  = EDGE_PIPE_NUM;
  localparam int VW   = VERTEX_BRAM_DWIDTH;
  localparam int WD   = WEIGHT_DWIDTH;
  localparam int DCN  = DST_CH_NUM;
  localparam int DIW  = DST_ID_DWIDTH;
  localparam int MW   = MASK_WIDTH;
  localparam int TAIW = TOT_ACC_ID_WIDTH;

  logic                mode;
  logic [VW*EPN-1:0]   front_src_p;
  logic [WD*EPN-1:0]   front_weight;
  logic [EPN-1:0]      front_src_p_mask;
  logic [TAIW-1:0]     front_tot_acc_id;
  logic                front_src_p_valid;
  logic [DIW*DCN-1:0]  front_dst_id;
  logic [MW*DCN-1:0]   front_src_p_mask_r;
  logic [DCN-1:0]      front_dst_valid;
  logic                front_ready;
  logic [VW*EPN-1:0]   src_p;
  logic [TAIW-1:0]     tot_acc_id;
  logic                src_p_valid;
  logic [DIW*DCN-1:0]  dst_id;
  logic [MW*DCN-1:0]   src_p_mask_r;
  logic [DCN-1:0]      dst_valid;
  logic                out_ready;
  logic [31:0]         stat_edge_cnt;

  modport master (
    output mode, front_src_p, front_weight, front_src_p_mask,
    output front_tot_acc_id, front_src_p_valid, front_dst_id,
    output front_src_p_mask_r, front_dst_valid, out_ready,
    input  front_ready, src_p, tot_acc_id, src_p_valid, dst_id,
    input  src_p_mask_r, dst_valid, stat_edge_cnt
  );

  modport slave (
    input  mode, front_src_p, front_weight, front_src_p_mask,
    input  front_tot_acc_id, front_src_p_valid, front_dst_id,
    input  front_src_p_mask_r, front_dst_valid, out_ready,
    output front_ready, src_p, tot_acc_id, src_p_valid, dst_id,
    output src_p_mask_r, dst_valid, stat_edge_cnt
  );
endinterface

// File: rtl/edge_process_gen.sv
// BFS/SSSP edge-process stage: per-lane saturating property update
// with a 2-entry (OUT + SKID) valid/ready buffer.
module edge_process_gen #(
  parameter int EDGE_PIPE_NUM      = 4,
  parameter int VERTEX_BRAM_DWIDTH = 32,
  parameter int WEIGHT_DWIDTH      = 8,
  parameter int DST_CH_NUM         = 4,
  parameter int DST_ID_DWIDTH      = 20,
  parameter int MASK_WIDTH         = 4,
  parameter int TOT_ACC_ID_WIDTH   = 4,
  parameter logic [VERTEX_BRAM_DWIDTH-1:0] MAX_SRC_P = '1
) (
  input logic          clk,
  input logic          rst,
  edge_process_if.slave bus
);
  localparam int EPN  = EDGE_PIPE_NUM;
  localparam int VW   = VERTEX_BRAM_DWIDTH;
  localparam int WD   = WEIGHT_DWIDTH;
  localparam int DCN  = DST_CH_NUM;
  localparam int DIW  = DST_ID_DWIDTH;
  localparam int MW   = MASK_WIDTH;
  localparam int TAIW = TOT_ACC_ID_WIDTH;

  typedef struct packed {
    logic [VW*EPN-1:0]  src_p;
    logic [EPN-1:0]     mask;
    logic [TAIW-1:0]    acc;
    logic               spv;
    logic [DIW*DCN-1:0] dst_id;
    logic [MW*DCN-1:0]  mask_r;
    logic [DCN-1:0]     dv;
  } beat_t;

  localparam beat_t EMPTY = '{acc: '1, default: '0};

  beat_t out_q, skid_q, nb;
  logic  skid_vld;
  logic  present, accept, out_valid, pop;
  logic [31:0] cnt_q;

  // Sum held in VW+1 bits so the carry out counts as saturation.
  function automatic logic [VW-1:0] upd(
    input logic [VW-1:0] src,
    input logic [WD-1:0] w,
    input logic          m,
    input logic          md
  );
    logic [VW:0] sum;
    logic [VW:0] inc;
    inc = md ? {{(VW+1-WD){1'b0}}, w} : {{VW{1'b0}}, 1'b1};
    sum = {1'b0, src} + inc;
    if (!m || src == MAX_SRC_P)
      return MAX_SRC_P;
    else if (sum >= {1'b0, MAX_SRC_P})
      return MAX_SRC_P;
    else
      return sum[VW-1:0];
  endfunction

  function automatic logic [31:0] pcnt(input logic [EPN-1:0] m);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < EPN; i++)
      n = n + {31'd0, m[i]};
    return n;
  endfunction

  always_comb begin
    nb = EMPTY;
    if (bus.front_src_p_valid) begin
      nb.spv  = 1'b1;
      nb.acc  = bus.front_tot_acc_id;
      nb.mask = bus.front_src_p_mask;
      for (int i = 0; i < EPN; i++)
        nb.src_p[i*VW +: VW] = upd(
          bus.front_src_p[i*VW +: VW],
          bus.front_weight[i*WD +: WD],
          bus.front_src_p_mask[i], bus.mode);
    end
    nb.dv = bus.front_dst_valid;
    for (int c = 0; c < DCN; c++) begin
      if (bus.front_dst_valid[c]) begin
        nb.dst_id[c*DIW +: DIW] = bus.front_dst_id[c*DIW +: DIW];
        nb.mask_r[c*MW +: MW]   = bus.front_src_p_mask_r[c*MW +: MW];
      end
    end
  end

  assign present   = bus.front_src_p_valid | (|bus.front_dst_valid);
  assign accept    = present & ~skid_vld;
  assign out_valid = out_q.spv | (|out_q.dv);
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= EMPTY;
      skid_q   <= EMPTY;
      skid_vld <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (!skid_vld) begin
        if (!out_valid || pop)
          out_q <= accept ? nb : EMPTY;
        else if (accept) begin
          skid_q   <= nb;
          skid_vld <= 1'b1;
        end
      end else if (pop) begin
        out_q    <= skid_q;
        skid_q   <= EMPTY;
        skid_vld <= 1'b0;
      end
      if (pop && out_q.spv)
        cnt_q <= cnt_q + pcnt(out_q.mask);
    end
  end

  assign bus.front_ready   = ~skid_vld;
  assign bus.src_p         = out_q.src_p;
  assign bus.tot_acc_id    = out_q.acc;
  assign bus.src_p_valid   = out_q.spv;
  assign bus.dst_id        = out_q.dst_id;
  assign bus.src_p_mask_r  = out_q.mask_r;
  assign bus.dst_valid     = out_q.dv;
  assign bus.stat_edge_cnt = cnt_q;
endmodule

// File: tb/tb_edge_process_gen.sv
// Bench for edge_process_gen: queue model of the stage plus
// literal vectors for the saturating lane update and buffering.
module tb_edge_process_gen;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_process_if bus ();

  edge_process_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [127:0] src_p;
    logic [3:0]   mask;
    logic [3:0]   acc;
    logic         spv;
    logic [79:0]  dst_id;
    logic [15:0]  mask_r;
    logic [3:0]   dv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mcnt = '0;
  bit   run_chk = 1'b0;

  task automatic chk(input string nm, input logic [159:0] a,
                     input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] l0,
    input logic [31:0] l1, input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Expected output beat computed directly from the lane rules.
  function automatic exp_t mk();
    exp_t e;
    longint s, r;
    e.src_p = '0; e.mask = '0; e.acc = 4'hF; e.spv = 1'b0;
    e.dst_id = '0; e.mask_r = '0; e.dv = bus.front_dst_valid;
    if (bus.front_src_p_valid) begin
      e.spv  = 1'b1;
      e.acc  = bus.front_tot_acc_id;
      e.mask = bus.front_src_p_mask;
      for (int i = 0; i < 4; i++) begin
        s = longint'(bus.front_src_p[i*32 +: 32]);
        if (!bus.front_src_p_mask[i] || s == longint'(MAX)) r = longint'(MAX);
        else begin
          r = s + (bus.mode ? longint'(bus.front_weight[i*8 +: 8]) : 1);
          if (r > longint'(MAX)) r = longint'(MAX);
        end
        e.src_p[i*32 +: 32] = r[31:0];
      end
    end
    for (int c = 0; c < 4; c++)
      if (bus.front_dst_valid[c]) begin
        e.dst_id[c*20 +: 20] = bus.front_dst_id[c*20 +: 20];
        e.mask_r[c*4 +: 4]   = bus.front_src_p_mask_r[c*4 +: 4];
      end
    return e;
  endfunction

  always @(posedge clk) begin
    bit acc;
    exp_t nb;
    if (rst) begin
      q.delete();
      mcnt = '0;
    end else begin
      acc = (bus.front_src_p_valid || (|bus.front_dst_valid)) && q.size() < 2;
      nb = mk();
      if (q.size() > 0 && bus.out_ready) begin
        if (q[0].spv) mcnt = mcnt + $countones(q[0].mask);
        void'(q.pop_front());
      end
      if (acc) q.push_back(nb);
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("front_ready", {159'd0, bus.front_ready}, {159'd0, q.size() < 2});
      chk("stat_cnt", {128'd0, bus.stat_edge_cnt}, {128'd0, mcnt});
      if (q.size() > 0) begin
        chk("src_p", {32'd0, bus.src_p}, {32'd0, q[0].src_p});
        chk("spv", {159'd0, bus.src_p_valid}, {159'd0, q[0].spv});
        chk("acc_id", {156'd0, bus.tot_acc_id}, {156'd0, q[0].acc});
        chk("dst_id", {80'd0, bus.dst_id}, {80'd0, q[0].dst_id});
        chk("mask_r", {144'd0, bus.src_p_mask_r}, {144'd0, q[0].mask_r});
        chk("dst_valid", {156'd0, bus.dst_valid}, {156'd0, q[0].dv});
      end else begin
        chk("idle_spv", {159'd0, bus.src_p_valid}, 160'd0);
        chk("idle_dv", {156'd0, bus.dst_valid}, 160'd0);
        chk("idle_acc", {156'd0, bus.tot_acc_id}, 160'hF);
      end
    end
  end

  task automatic idle_in();
    bus.front_src_p_valid = 1'b0;
    bus.front_dst_valid   = '0;
    bus.front_src_p       = '0;
    bus.front_weight      = '0;
    bus.front_src_p_mask  = '0;
  endtask

  task automatic send(input logic md, input logic [127:0] src,
    input logic [31:0] w, input logic [3:0] m, input logic sv,
    input logic [3:0] acc, input logic [3:0] dv);
    bit ok;
    bus.mode               = md;
    bus.front_src_p        = src;
    bus.front_weight       = w;
    bus.front_src_p_mask   = m;
    bus.front_src_p_valid  = sv;
    bus.front_tot_acc_id   = acc;
    bus.front_dst_valid    = dv;
    bus.front_dst_id       = {20'hABCDE, 20'h12345, 20'h0F0F0, 20'h00777} ^ {80{acc[0]}};
    bus.front_src_p_mask_r = 16'hC3A5 ^ {4{acc}};
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk);
      ok = bus.front_ready;
    end
    #1;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout act=0 exp=1");
    end
    idle_in();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout act=%0d exp=0", q.size());
    end
  endtask

  logic [31:0] c0;

  initial begin
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    bus.front_tot_acc_id = '0;
    bus.front_dst_id = '0;
    bus.front_src_p_mask_r = '0;
    idle_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {159'd0, bus.front_ready}, 160'd1);
    chk("rst_acc", {156'd0, bus.tot_acc_id}, 160'hF);
    chk("rst_src_p", {32'd0, bus.src_p}, 160'd0);
    chk("rst_cnt", {128'd0, bus.stat_edge_cnt}, 160'd0);
    run_chk = 1'b1;

    // 1: BFS with saturation at MAX
    c0 = bus.stat_edge_cnt;
    send(1'b0, pk(5, MAX, 0, MAX - 1), 32'd0, 4'b1111, 1'b1, 4'd3, 4'b0000);
    chk("t1_src_p", {32'd0, bus.src_p}, {32'd0, pk(6, MAX, 1, MAX)});
    chk("t1_spv", {159'd0, bus.src_p_valid}, 160'd1);
    @(posedge clk); #1;
    chk("t1_cnt", {128'd0, bus.stat_edge_cnt}, {128'd0, c0 + 32'd4});

    // 2: SSSP with weights, lane 2 masked
    c0 = bus.stat_edge_cnt;
    send(1'b1, pk(10, 7, MAX - 100, MAX - 2), {8'd2, 8'd255, 8'd0, 8'd3},
         4'b1011, 1'b1, 4'd5, 4'b0000);
    chk("t2_src_p", {32'd0, bus.src_p}, {32'd0, pk(13, 7, MAX, MAX)});
    @(posedge clk); #1;
    chk("t2_cnt", {128'd0, bus.stat_edge_cnt}, {128'd0, c0 + 32'd3});

    // 3: stall with A, B, C offered
    bus.out_ready = 1'b0;
    send(1'b0, pk(100, 0, 0, 0), 32'd0, 4'b0001, 1'b1, 4'd1, 4'b0001);
    send(1'b0, pk(200, 0, 0, 0), 32'd0, 4'b0011, 1'b1, 4'd2, 4'b0010);
    bus.mode = 1'b0;
    bus.front_src_p = pk(300, 0, 0, 0);
    bus.front_src_p_mask = 4'b0111;
    bus.front_src_p_valid = 1'b1;
    bus.front_tot_acc_id = 4'd4;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t3_ready", {159'd0, bus.front_ready}, 160'd0);
      chk("t3_hold_A", {128'd0, bus.src_p[31:0]}, 160'd101);
    end
    bus.out_ready = 1'b1;
    send(1'b0, pk(300, 0, 0, 0), 32'd0, 4'b0111, 1'b1, 4'd4, 4'b0000);
    chk("t3_C_out", {128'd0, bus.src_p[31:0]}, 160'd301);
    drain();

    // 4: dst-only beat
    c0 = bus.stat_edge_cnt;
    send(1'b0, pk(9, 9, 9, 9), 32'd0, 4'b1111, 1'b0, 4'd6, 4'b0101);
    chk("t4_dv", {156'd0, bus.dst_valid}, 160'h5);
    chk("t4_spv", {159'd0, bus.src_p_valid}, 160'd0);
    chk("t4_acc", {156'd0, bus.tot_acc_id}, 160'hF);
    chk("t4_dst", {140'd0, bus.dst_id[39:20]}, 160'h0);
    @(posedge clk); #1;
    chk("t4_cnt", {128'd0, bus.stat_edge_cnt}, {128'd0, c0});

    // 5: reset while both entries full
    bus.out_ready = 1'b0;
    send(1'b0, pk(1, 2, 3, 4), 32'd0, 4'b1111, 1'b1, 4'd7, 4'b1111);
    send(1'b1, pk(1, 2, 3, 4), 32'h01010101, 4'b1111, 1'b1, 4'd8, 4'b0000);
    chk("t5_full", {159'd0, bus.front_ready}, 160'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_spv", {159'd0, bus.src_p_valid}, 160'd0);
    chk("t5_dv", {156'd0, bus.dst_valid}, 160'd0);
    chk("t5_ready", {159'd0, bus.front_ready}, 160'd1);
    chk("t5_cnt", {128'd0, bus.stat_edge_cnt}, 160'd0);

    // 6: mode toggles per beat, out_ready toggling
    for (int k = 0; k < 10; k++) begin
      bus.out_ready = (k % 3) != 1;
      send(k[0], pk(32'(k * 10), MAX - 3, 32'(k), 0),
           {8'd4, 8'd200, 8'd2, 8'(k + 1)}, 4'b1111 ^ 4'(k),
           1'b1, 4'(k), 4'(k * 3));
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
